fetch_stage: RTL and testbench

//  PC generator and instruction issue stage sitting directly downstream of fetchbuffer.

---
 rtl/fetch_stage_wires.sv | 47 ++++
 rtl/fetch_queue.sv | 73 +++++++
 rtl/fetch_stage.sv | 115 +++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_wires.sv
// Shared types for the fetch stage: memory-side records, queue entries and FSM states.
package fetch_stage_wires;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_ready;
    } mem_out_type;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        comp;
    } fetch_entry_type;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FENCE = 2'd2
    } fetch_state_type;

    typedef struct packed {
        logic            push;
        logic            pop;
        logic            flush;
        fetch_entry_type data;
    } queue_in_type;

    typedef struct packed {
        logic            valid;
        fetch_entry_type head;
    } queue_out_type;

    // Anything whose low two bits are not 2'b11 is a 16-bit compressed encoding.
    function automatic logic is_comp(input logic [31:0] instr);
        return instr[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small instruction FIFO between the PC generator and decode.
// Flush has priority over push/pop; the head entry reads out combinationally.
module fetch_queue
    import fetch_stage_wires::*;
#(
    parameter int DEPTH = 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  queue_in_type     q_in,
    output queue_out_type    q_out,
    output logic [DEPTH:0]   count
);

    localparam int ENTRIES = 2 ** DEPTH;

    fetch_entry_type  mem_q [ENTRIES];
    fetch_entry_type  mem_d [ENTRIES];
    logic [DEPTH-1:0] wptr_q, wptr_d;
    logic [DEPTH-1:0] rptr_q, rptr_d;
    logic [DEPTH:0]   count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (q_in.flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (q_in.push) begin
                mem_d[wptr_q] = q_in.data;
                wptr_d        = wptr_q + (DEPTH)'(1);
            end
            if (q_in.pop) begin
                rptr_d = rptr_q + (DEPTH)'(1);
            end
            if (q_in.push && !q_in.pop) begin
                count_d = count_q + (DEPTH + 1)'(1);
            end else if (!q_in.push && q_in.pop) begin
                count_d = count_q - (DEPTH + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        q_out.valid = count_q != '0;
        q_out.head  = q_out.valid ? mem_q[rptr_q] : '0;
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// PC generator and instruction issue stage: requests instructions from the fetchbuffer,
// queues the responses and hands them to decode, handling redirects and fence.i.
module fetch_stage
    import fetch_stage_wires::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int          QUEUE_DEPTH = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    input  logic        redirect_fence,
    input  mem_out_type fetchbuffer_out,
    output mem_in_type  fetchbuffer_in,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_npc,
    output logic [31:0] dec_instr,
    output logic        dec_comp,
    input  logic        dec_ready
);

    localparam logic [QUEUE_DEPTH:0] CAPACITY = (QUEUE_DEPTH + 1)'(2 ** QUEUE_DEPTH);

    typedef struct packed {
        fetch_state_type state;
        logic [31:0]     pc;
    } reg_type;

    reg_type                r_q, r_d;
    queue_in_type           q_in;
    queue_out_type          q_out;
    logic [QUEUE_DEPTH:0]   q_count;
    logic [31:0]            rdata;
    logic                   comp;
    logic                   fire;
    logic                   unused_addr_bit;

    assign unused_addr_bit = redirect_addr[0];

    always_comb begin
        r_d                      = r_q;
        q_in                     = '0;
        fetchbuffer_in           = '0;
        fetchbuffer_in.mem_instr = 1'b1;
        rdata                    = fetchbuffer_out.mem_rdata;
        comp                     = is_comp(rdata);

        // Request only depends on registered state, so dec_ready never reaches mem_valid.
        case (r_q.state)
            IDLE: begin
                r_d.state = RUN;
            end
            RUN: begin
                fetchbuffer_in.mem_valid = q_count < CAPACITY;
                fetchbuffer_in.mem_addr  = r_q.pc;
            end
            FENCE: begin
                fetchbuffer_in.mem_valid = 1'b1;
                fetchbuffer_in.mem_fence = 1'b1;
                fetchbuffer_in.mem_addr  = r_q.pc;
                r_d.state                = RUN;
            end
            default: begin
                r_d.state = IDLE;
            end
        endcase

        fire      = (r_q.state == RUN) && fetchbuffer_in.mem_valid && fetchbuffer_out.mem_ready;
        q_in.pop  = q_out.valid && dec_ready;

        if (redirect_valid) begin
            q_in.flush = 1'b1;
            q_in.pop   = 1'b0;
            r_d.pc     = {redirect_addr[31:1], 1'b0};
            if (r_q.state == RUN && redirect_fence) begin
                r_d.state = FENCE;
            end
        end else if (fire) begin
            q_in.push       = 1'b1;
            q_in.data.pc    = r_q.pc;
            q_in.data.instr = comp ? {16'h0000, rdata[15:0]} : rdata;
            q_in.data.comp  = comp;
            r_d.pc          = r_q.pc + (comp ? 32'd2 : 32'd4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q.state <= IDLE;
            r_q.pc    <= {RESET_PC[31:1], 1'b0};
        end else begin
            r_q <= r_d;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .q_in  (q_in),
        .q_out (q_out),
        .count (q_count)
    );

    assign dec_valid = q_out.valid;
    assign dec_pc    = q_out.head.pc;
    assign dec_instr = q_out.head.instr;
    assign dec_comp  = q_out.head.comp;
    assign dec_npc   = q_out.valid ? q_out.head.pc + (q_out.head.comp ? 32'd2 : 32'd4) : 32'd0;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_fetch_stage;
    import fetch_stage_wires::*;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          CAP      = 2;
    localparam int          PH_IDLE  = 0;
    localparam int          PH_RUN   = 1;
    localparam int          PH_FENCE = 2;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        redirect_fence;
    mem_out_type mem_out;
    mem_in_type  mem_in;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_npc;
    logic [31:0] dec_instr;
    logic        dec_comp;
    logic        dec_ready;

    int tests_run = 0;
    int failed    = 0;

    fetch_stage #(
        .RESET_PC    (RESET_PC),
        .QUEUE_DEPTH (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr),
        .redirect_fence  (redirect_fence),
        .fetchbuffer_out (mem_out),
        .fetchbuffer_in  (mem_in),
        .dec_valid       (dec_valid),
        .dec_pc          (dec_pc),
        .dec_npc         (dec_npc),
        .dec_instr       (dec_instr),
        .dec_comp        (dec_comp),
        .dec_ready       (dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an unbounded queue capped at CAP entries plus the current pc and phase.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        comp;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc    = RESET_PC;
    int          m_phase = PH_IDLE;

    task automatic modelStep();
        ent_t e;
        bit   accept;
        accept = (m_phase == PH_RUN) && (m_q.size() < CAP) && mem_out.mem_ready;
        if (rst) begin
            m_q.delete();
            m_pc    = RESET_PC;
            m_phase = PH_IDLE;
        end else if (redirect_valid) begin
            m_q.delete();
            m_pc    = {redirect_addr[31:1], 1'b0};
            m_phase = (m_phase == PH_RUN && redirect_fence) ? PH_FENCE : PH_RUN;
        end else begin
            if (m_q.size() > 0 && dec_ready) void'(m_q.pop_front());
            if (accept) begin
                e.comp  = mem_out.mem_rdata[1:0] != 2'b11;
                e.instr = e.comp ? (mem_out.mem_rdata & 32'h0000_FFFF) : mem_out.mem_rdata;
                e.pc    = m_pc;
                m_q.push_back(e);
                m_pc = m_pc + (e.comp ? 32'd2 : 32'd4);
            end
            m_phase = PH_RUN;
        end
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        logic        e_dv;
        logic [31:0] e_pc, e_instr, e_npc;
        logic        e_comp;
        e_dv    = m_q.size() > 0;
        e_pc    = e_dv ? m_q[0].pc : 32'd0;
        e_instr = e_dv ? m_q[0].instr : 32'd0;
        e_comp  = e_dv ? m_q[0].comp : 1'b0;
        e_npc   = e_dv ? m_q[0].pc + (m_q[0].comp ? 32'd2 : 32'd4) : 32'd0;
        check("mdl_dec_valid", 32'(dec_valid), 32'(e_dv));
        check("mdl_dec_pc", dec_pc, e_pc);
        check("mdl_dec_instr", dec_instr, e_instr);
        check("mdl_dec_comp", 32'(dec_comp), 32'(e_comp));
        check("mdl_dec_npc", dec_npc, e_npc);
        check("mdl_mem_valid", 32'(mem_in.mem_valid),
              32'((m_phase == PH_RUN && m_q.size() < CAP) || m_phase == PH_FENCE));
        check("mdl_mem_fence", 32'(mem_in.mem_fence), 32'(m_phase == PH_FENCE));
        check("mdl_mem_addr", mem_in.mem_addr, (m_phase == PH_IDLE) ? 32'd0 : m_pc);
        check("mdl_mem_instr", 32'(mem_in.mem_instr), 32'd1);
        check("mdl_mem_wdata", mem_in.mem_wdata, 32'd0);
        check("mdl_mem_wstrb", 32'(mem_in.mem_wstrb), 32'd0);
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] ra,
                                 input logic rf, input logic mr, input logic [31:0] rd,
                                 input logic dr);
        rst               = r;
        redirect_valid    = rv;
        redirect_addr     = ra;
        redirect_fence    = rf;
        mem_out.mem_ready = mr;
        mem_out.mem_rdata = rd;
        dec_ready         = dr;
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    typedef struct {
        logic        rst;
        logic        mem_ready;
        logic        dec_ready;
        logic [31:0] rdata;
        logic        exp_dec_valid;
        logic [31:0] exp_dec_pc;
        logic [31:0] exp_dec_instr;
        logic        exp_mem_valid;
        logic [31:0] exp_mem_addr;
    } vec_t;

    vec_t        vecs[9];
    logic [31:0] t2_pcs[4]    = '{32'h8000_0000, 32'h8000_0002, 32'h8000_0006, 32'h8000_0008};
    logic [31:0] t2_instrs[4] = '{32'h0000_4501, 32'h00A0_0093, 32'h0000_4501, 32'h00A0_0093};

    initial begin
        logic [31:0] rd;
        logic        rv, rf;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,          32'h0,  1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h13, 1'b0, 32'h0,          32'h0,  1'b1, 32'h8000_0000};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h13, 1'b1, 32'h8000_0000,  32'h13, 1'b1, 32'h8000_0004};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h13, 1'b1, 32'h8000_0004,  32'h13, 1'b1, 32'h8000_0008};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h13, 1'b1, 32'h8000_0008,  32'h13, 1'b1, 32'h8000_000C};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h13, 1'b1, 32'h8000_0008,  32'h13, 1'b0, 32'h8000_0010};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h13, 1'b1, 32'h8000_0008,  32'h13, 1'b0, 32'h8000_0010};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 32'h13, 1'b1, 32'h8000_000C,  32'h13, 1'b1, 32'h8000_0010};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 32'h13, 1'b1, 32'h8000_0010,  32'h13, 1'b1, 32'h8000_0014};

        // Sequential fetch, then back-pressure filling the queue and resuming.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].rst, 1'b0, 32'h0, 1'b0, vecs[i].mem_ready, vecs[i].rdata,
                          vecs[i].dec_ready);
            check($sformatf("vec%0d_dec_valid", i), 32'(dec_valid), 32'(vecs[i].exp_dec_valid));
            check($sformatf("vec%0d_dec_pc", i), dec_pc, vecs[i].exp_dec_pc);
            check($sformatf("vec%0d_dec_instr", i), dec_instr, vecs[i].exp_dec_instr);
            check($sformatf("vec%0d_mem_valid", i), 32'(mem_in.mem_valid), 32'(vecs[i].exp_mem_valid));
            check($sformatf("vec%0d_mem_addr", i), mem_in.mem_addr, vecs[i].exp_mem_addr);
        end

        // Mixed 16/32-bit stepping.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, (i % 2 == 0) ? 32'h0000_4501 : 32'h00A0_0093, 1'b1);
            check($sformatf("mix%0d_dec_pc", i), dec_pc, t2_pcs[i]);
            check($sformatf("mix%0d_dec_instr", i), dec_instr, t2_instrs[i]);
            check($sformatf("mix%0d_dec_comp", i), 32'(dec_comp), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Redirect with a full queue and mem_ready high.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13, 1'b0);
        check("full_mem_valid", 32'(mem_in.mem_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h8000_0101, 1'b0, 1'b1, 32'h13, 1'b1);
        check("redir_dec_valid", 32'(dec_valid), 32'd0);
        check("redir_mem_addr", mem_in.mem_addr, 32'h8000_0100);
        check("redir_mem_valid", 32'(mem_in.mem_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13, 1'b0);
        check("redir_first_pc", dec_pc, 32'h8000_0100);

        // fence.i redirect: one fence cycle, then fetch from the new pc.
        applyStimulus(1'b0, 1'b1, 32'h8000_0200, 1'b1, 1'b1, 32'h13, 1'b0);
        check("fence_mem_fence", 32'(mem_in.mem_fence), 32'd1);
        check("fence_mem_valid", 32'(mem_in.mem_valid), 32'd1);
        check("fence_dec_valid", 32'(dec_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13, 1'b0);
        check("post_fence_fence", 32'(mem_in.mem_fence), 32'd0);
        check("post_fence_addr", mem_in.mem_addr, 32'h8000_0200);
        check("post_fence_dec_valid", 32'(dec_valid), 32'd0);

        // Reset while full with a request pending.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13, 1'b0);
        check("prerst_dec_valid", 32'(dec_valid), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13, 1'b0);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_mem_valid", 32'(mem_in.mem_valid), 32'd0);
        check("rst_mem_addr", mem_in.mem_addr, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13, 1'b0);
        check("rst_resume_addr", mem_in.mem_addr, RESET_PC);
        check("rst_resume_valid", 32'(mem_in.mem_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13, 1'b0);
        check("rst_resume_pc", dec_pc, RESET_PC);

        // Randomized traffic against the reference model.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            rd = $urandom;
            rv = ($urandom_range(0, 15) == 0);
            rf = ($urandom_range(0, 3) == 0);
            applyStimulus(($urandom_range(0, 63) == 0), rv, $urandom, rf,
                          ($urandom_range(0, 1) == 1), rd, ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
